pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the RV32IM pipeline, the generic successor of the fixed-field ID/EX latch. It carries an opaque payload (PC, PC+4, IMM, operands, rd, func3) and a control field (regwrite, memwrite, memread, branch, jump, ALU op, ...) between stages with valid/ready handshaking. It adds an optional skid entry, a synchronous flush that inserts a bubble, and saturating stall and bubble counters for the hazard unit and debug.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/sat_counter.sv | 39 +++
 rtl/pipe_stage_reg.sv | 133 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the RV32IM pipeline. Holds the
//                pipeline stage state encodings and the control-field bit map.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Stage occupancy encodings
    localparam logic [1:0] STATE_EMPTY = 2'd0;
    localparam logic [1:0] STATE_ONE   = 2'd1;
    localparam logic [1:0] STATE_TWO   = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = STATE_EMPTY,
        ST_ONE   = STATE_ONE,
        ST_TWO   = STATE_TWO
    } stage_state_t;

    // Control-field bit positions
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_JUMP     = 4;
    localparam int CTRL_JAL      = 5;
    localparam int CTRL_TWOSCOMP = 6;
    localparam int CTRL_MUX1     = 7;
    localparam int CTRL_MUX2     = 8;
    localparam int CTRL_MUX3     = 9;
    localparam int CTRL_ALU_LSB  = 10;
    localparam int CTRL_ALU_MSB  = 14;

    // Number of valid entries a stage holds in a given state
    function automatic logic [1:0] held_entries(input stage_state_t s);
        logic [1:0] n;
        case (s)
            ST_ONE:  n = 2'd1;
            ST_TWO:  n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter; adds 0..3 per enabled edge and sticks
//                at its all-ones value instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         inc_en,
    input  logic [1:0]   inc_amt,
    output logic [W-1:0] count
);

    localparam logic [W:0] c_sat_max = {1'b0, {W{1'b1}}};

    logic [W-1:0] r_count;
    logic [W:0]   w_sum;
    logic [W-1:0] w_next;

    // One extra bit of headroom so overflow is visible before clamping
    assign w_sum  = {1'b0, r_count} + {{(W-1){1'b0}}, inc_amt};
    assign w_next = (w_sum > c_sat_max) ? c_sat_max[W-1:0] : w_sum[W-1:0];
    assign count  = r_count;

    // Count register, cleared only by reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_count <= '0;
        end else if (inc_en) begin
            r_count <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Generic valid/ready pipeline stage register with optional
//                skid entry, synchronous flush-to-bubble and saturating
//                stall / bubble counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [CTRL_W-1:0] IN_CTRL,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CTRL_W-1:0] OUT_CTRL,
    input  logic              FLUSH,
    input  logic              BUSYWAIT,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic [CNT_W-1:0]  BUBBLE_CNT
);

    import cpu_pkg::*;

    stage_state_t      r_state;
    logic              r_live;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_out_valid;
    logic w_in_ready;
    logic w_acc;
    logic w_pop;
    logic w_stall_inc;

    assign w_out_valid = (r_state != ST_EMPTY);

    // Skid variant decouples IN_READY from OUT_READY; the 1-entry variant
    // passes downstream readiness straight through.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign w_in_ready = r_live & ~BUSYWAIT & (r_state != ST_TWO);
        end else begin : g_pass_ready
            assign w_in_ready = r_live & ~BUSYWAIT & (~w_out_valid | OUT_READY);
        end
    endgenerate

    assign w_acc = IN_VALID & w_in_ready;
    assign w_pop = w_out_valid & OUT_READY & ~BUSYWAIT;

    assign IN_READY  = w_in_ready;
    assign OUT_VALID = w_out_valid;
    assign OUT_DATA  = r_main_data;
    // Control of a bubble must read as NOP downstream
    assign OUT_CTRL  = w_out_valid ? r_main_ctrl : '0;

    // Occupancy FSM and entry storage; flush beats every other event
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_EMPTY;
            r_live      <= 1'b0;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_live <= 1'b1;
            if (FLUSH) begin
                r_state <= ST_EMPTY;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_acc) begin
                            r_main_data <= IN_DATA;
                            r_main_ctrl <= IN_CTRL;
                            r_state     <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (w_acc && w_pop) begin
                            r_main_data <= IN_DATA;
                            r_main_ctrl <= IN_CTRL;
                        end else if (w_acc) begin
                            r_skid_data <= IN_DATA;
                            r_skid_ctrl <= IN_CTRL;
                            r_state     <= ST_TWO;
                        end else if (w_pop) begin
                            r_state     <= ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (w_pop) begin
                            r_main_data <= r_skid_data;
                            r_main_ctrl <= r_skid_ctrl;
                            r_state     <= ST_ONE;
                        end
                    end
                    default: r_state <= ST_EMPTY;
                endcase
            end
        end
    end

    assign w_stall_inc = ~FLUSH & ((w_out_valid & ~OUT_READY) | BUSYWAIT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK     (CLK),
        .RESET   (RESET),
        .inc_en  (w_stall_inc),
        .inc_amt (2'd1),
        .count   (STALL_CNT)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .CLK     (CLK),
        .RESET   (RESET),
        .inc_en  (FLUSH),
        .inc_amt (held_entries(r_state)),
        .count   (BUBBLE_CNT)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Scoreboard bench for pipe_stage_reg (skid, saturation and
//                pass-through variants).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    import cpu_pkg::*;

    logic         clk;
    logic         rst_n;

    // Main instance: SKID=1, CNT_W=16
    logic         r_in_valid, r_out_ready, r_flush, r_busy;
    logic [127:0] r_in_data;
    logic [15:0]  r_in_ctrl;
    logic         w_in_ready, w_out_valid;
    logic [127:0] w_out_data;
    logic [15:0]  w_out_ctrl, w_stall, w_bubble;

    // Saturation instance: CNT_W=4
    logic         r_sat_busy;
    logic         w_sat_in_ready, w_sat_out_valid;
    logic [7:0]   w_sat_out_data;
    logic [15:0]  w_sat_out_ctrl;
    logic [3:0]   w_sat_stall, w_sat_bubble;

    // Pass-through instance: SKID=0
    logic         r_ns_in_valid, r_ns_out_ready;
    logic [7:0]   r_ns_in_data;
    logic         w_ns_in_ready, w_ns_out_valid;
    logic [7:0]   w_ns_out_data;
    logic [15:0]  w_ns_out_ctrl, w_ns_stall, w_ns_bubble;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] exp_d[$];
    logic [15:0]  exp_c[$];

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(16), .SKID(1), .CNT_W(16)) u_dut (
        .CLK(clk), .RESET(rst_n), .IN_VALID(r_in_valid), .IN_READY(w_in_ready),
        .IN_DATA(r_in_data), .IN_CTRL(r_in_ctrl), .OUT_VALID(w_out_valid),
        .OUT_READY(r_out_ready), .OUT_DATA(w_out_data), .OUT_CTRL(w_out_ctrl),
        .FLUSH(r_flush), .BUSYWAIT(r_busy), .STALL_CNT(w_stall), .BUBBLE_CNT(w_bubble)
    );

    pipe_stage_reg #(.DATA_W(8), .CTRL_W(16), .SKID(1), .CNT_W(4)) u_sat (
        .CLK(clk), .RESET(rst_n), .IN_VALID(1'b0), .IN_READY(w_sat_in_ready),
        .IN_DATA(8'h00), .IN_CTRL(16'h0000), .OUT_VALID(w_sat_out_valid),
        .OUT_READY(1'b1), .OUT_DATA(w_sat_out_data), .OUT_CTRL(w_sat_out_ctrl),
        .FLUSH(1'b0), .BUSYWAIT(r_sat_busy), .STALL_CNT(w_sat_stall), .BUBBLE_CNT(w_sat_bubble)
    );

    pipe_stage_reg #(.DATA_W(8), .CTRL_W(16), .SKID(0), .CNT_W(16)) u_ns (
        .CLK(clk), .RESET(rst_n), .IN_VALID(r_ns_in_valid), .IN_READY(w_ns_in_ready),
        .IN_DATA(r_ns_in_data), .IN_CTRL(16'h0001), .OUT_VALID(w_ns_out_valid),
        .OUT_READY(r_ns_out_ready), .OUT_DATA(w_ns_out_data), .OUT_CTRL(w_ns_out_ctrl),
        .FLUSH(1'b0), .BUSYWAIT(1'b0), .STALL_CNT(w_ns_stall), .BUBBLE_CNT(w_ns_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] mk_ctrl(input int alu, input bit rw, input bit mr);
        logic [15:0] c;
        c = '0;
        c[CTRL_REGWRITE] = rw;
        c[CTRL_MEMREAD]  = mr;
        c[CTRL_ALU_MSB:CTRL_ALU_LSB] = alu[4:0];
        return c;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [127:0] d, input logic [15:0] c);
        exp_d.push_back(d);
        exp_c.push_back(c);
    endtask

    task automatic drop_all();
        exp_d.delete();
        exp_c.delete();
    endtask

    // Present one entry until accepted (bounded), then return just after the accepting edge
    task automatic send(input logic [127:0] d, input logic [15:0] c);
        int t;
        bit done;
        t = 0;
        done = 0;
        r_in_valid = 1'b1;
        r_in_data  = d;
        r_in_ctrl  = c;
        while (!done) begin
            @(negedge clk);
            if (w_in_ready) begin
                push(d, c);
                done = 1;
            end else if (t > 50) begin
                n_vec++;
                n_err++;
                $display("FAIL send_timeout: got no IN_READY expected acceptance of %0h", d);
                done = 1;
            end
            t++;
            step();
        end
    endtask

    // Scoreboard monitor: compare every entry the main instance hands downstream
    always @(negedge clk) begin
        if (rst_n && w_out_valid && r_out_ready && !r_busy && !r_flush) begin
            n_vec++;
            if (exp_d.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %0h expected no output", w_out_data);
            end else begin
                logic [127:0] ed;
                logic [15:0]  ec;
                ed = exp_d.pop_front();
                ec = exp_c.pop_front();
                if (w_out_data !== ed || w_out_ctrl !== ec) begin
                    n_err++;
                    $display("FAIL sb_data: got %0h/%0h expected %0h/%0h", w_out_data, w_out_ctrl, ed, ec);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        r_in_valid = 1'b1; r_in_data = 128'hAA; r_in_ctrl = 16'hFFFF;
        r_out_ready = 1'b1; r_flush = 1'b0; r_busy = 1'b0;
        r_sat_busy = 1'b0;
        r_ns_in_valid = 1'b0; r_ns_in_data = 8'h00; r_ns_out_ready = 1'b1;

        // ---- Reset held 3 cycles with IN_VALID=1
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", w_out_valid, 0);
        chk("rst_out_ctrl",  w_out_ctrl, 0);
        chk("rst_out_data",  w_out_data, 0);
        chk("rst_in_ready",  w_in_ready, 0);
        chk("rst_stall",     w_stall, 0);
        chk("rst_bubble",    w_bubble, 0);
        step();
        rst_n = 1'b1;
        r_in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("rel_in_ready", w_in_ready, 1);
        step();

        // ---- Streaming: 0x10..0x13 back-to-back
        for (int i = 0; i < 4; i++) begin
            r_in_valid = 1'b1;
            r_in_data  = 128'h10 + 128'(i);
            r_in_ctrl  = mk_ctrl(i + 1, 1'b1, 1'b0);
            @(negedge clk);
            chk("str_in_ready", w_in_ready, 1);
            push(r_in_data, r_in_ctrl);
            if (i > 0) begin
                chk("str_out_valid", w_out_valid, 1);
                chk("str_out_data", w_out_data, 128'h10 + 128'(i - 1));
            end
            step();
        end
        r_in_valid = 1'b0;
        @(negedge clk);
        chk("str_last", w_out_data, 128'h13);
        step();
        @(negedge clk);
        chk("str_drained", w_out_valid, 0);
        chk("str_stall", w_stall, 0);
        step();

        // ---- Backpressure into TWO
        r_out_ready = 1'b0;
        r_in_valid = 1'b1; r_in_data = 128'h20; r_in_ctrl = mk_ctrl(2, 1'b1, 1'b1);
        @(negedge clk);
        chk("bp_rdy_a", w_in_ready, 1);
        push(r_in_data, r_in_ctrl);
        step();
        r_in_data = 128'h21; r_in_ctrl = mk_ctrl(3, 1'b0, 1'b1);
        @(negedge clk);
        chk("bp_rdy_b", w_in_ready, 1);
        push(r_in_data, r_in_ctrl);
        step();
        r_in_data = 128'h22; r_in_ctrl = mk_ctrl(4, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_full_c", w_in_ready, 0);
        chk("bp_head", w_out_data, 128'h20);
        step();
        @(negedge clk);
        chk("bp_full_d", w_in_ready, 0);
        step();
        r_out_ready = 1'b1;
        send(128'h22, mk_ctrl(4, 1'b1, 1'b0));
        r_in_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("bp_stall", w_stall, 3);
        chk("bp_q_empty", 128'(exp_d.size()), 0);
        step();

        // ---- Flush while holding two entries, with a same-cycle input
        r_out_ready = 1'b0;
        r_in_valid = 1'b1; r_in_data = 128'h40; r_in_ctrl = mk_ctrl(5, 1'b1, 1'b0);
        @(negedge clk);
        push(r_in_data, r_in_ctrl);
        step();
        r_in_data = 128'h41; r_in_ctrl = mk_ctrl(6, 1'b1, 1'b0);
        @(negedge clk);
        push(r_in_data, r_in_ctrl);
        step();
        r_in_data = 128'h30; r_in_ctrl = mk_ctrl(7, 1'b1, 1'b0);
        r_flush = 1'b1;
        @(negedge clk);
        chk("fl2_in_ready", w_in_ready, 0);
        drop_all();
        step();
        r_flush = 1'b0;
        r_in_valid = 1'b0;
        @(negedge clk);
        chk("fl2_out_valid", w_out_valid, 0);
        chk("fl2_out_ctrl",  w_out_ctrl, 0);
        chk("fl2_out_data",  w_out_data, 128'h40);
        chk("fl2_bubble",    w_bubble, 2);
        chk("fl2_stall",     w_stall, 4);
        step();
        @(negedge clk);
        chk("fl2_no_0x30", w_out_valid, 0);
        step();

        // ---- Flush with one entry while an input is accepted and dropped
        r_in_valid = 1'b1; r_in_data = 128'h50; r_in_ctrl = mk_ctrl(8, 1'b0, 1'b0);
        @(negedge clk);
        push(r_in_data, r_in_ctrl);
        step();
        r_in_data = 128'h51; r_in_ctrl = mk_ctrl(9, 1'b0, 1'b0);
        r_flush = 1'b1;
        @(negedge clk);
        chk("fl1_in_ready", w_in_ready, 1);
        drop_all();
        step();
        r_flush = 1'b0;
        r_in_valid = 1'b0;
        @(negedge clk);
        chk("fl1_out_valid", w_out_valid, 0);
        chk("fl1_bubble",    w_bubble, 3);
        chk("fl1_stall",     w_stall, 4);
        chk("fl1_out_data",  w_out_data, 128'h50);
        step();

        // ---- BUSYWAIT freeze for 5 cycles, then flush under BUSYWAIT
        r_out_ready = 1'b1;
        send(128'h60, mk_ctrl(10, 1'b1, 1'b1));
        r_busy = 1'b1;
        r_in_data = 128'h61; r_in_ctrl = mk_ctrl(11, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bw_out_valid", w_out_valid, 1);
            chk("bw_out_data",  w_out_data, 128'h60);
            chk("bw_out_ctrl",  w_out_ctrl, mk_ctrl(10, 1'b1, 1'b1));
            chk("bw_in_ready",  w_in_ready, 0);
            step();
        end
        r_flush = 1'b1;
        @(negedge clk);
        drop_all();
        step();
        r_flush = 1'b0;
        r_busy = 1'b0;
        r_in_valid = 1'b0;
        @(negedge clk);
        chk("bwfl_out_valid", w_out_valid, 0);
        chk("bwfl_stall",     w_stall, 9);
        chk("bwfl_bubble",    w_bubble, 4);
        step();

        // ---- Saturation with CNT_W=4
        r_sat_busy = 1'b1;
        repeat (14) step();
        @(negedge clk);
        chk("sat_14", w_sat_stall, 14);
        step();
        repeat (5) step();
        @(negedge clk);
        chk("sat_15", w_sat_stall, 15);
        r_sat_busy = 1'b0;
        step();

        // ---- SKID=0: IN_READY follows OUT_READY in the same cycle
        r_ns_in_valid = 1'b1; r_ns_in_data = 8'h77;
        @(negedge clk);
        chk("ns_rdy_empty", w_ns_in_ready, 1);
        step();
        r_ns_out_ready = 1'b0;
        r_ns_in_data = 8'h78;
        #1;
        chk("ns_rdy_low",  w_ns_in_ready, 0);
        chk("ns_head",     w_ns_out_data, 8'h77);
        r_ns_out_ready = 1'b1;
        #1;
        chk("ns_rdy_high", w_ns_in_ready, 1);
        step();
        r_ns_in_valid = 1'b0;
        @(negedge clk);
        chk("ns_replace",  w_ns_out_data, 8'h78);
        chk("ns_valid",    w_ns_out_valid, 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
